// File: rtl/mux_demux_pkg.sv
// Shared types and helpers for the mux_demux_n slot switch.
// The slot state enum and the select-width helper live here.
package mux_demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin source grant for mux_demux_n: searches upward from the last
// granted channel + 1 and advances its pointer only when a beat is accepted.
module rr_arbiter_n
    import mux_demux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             accept,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [SEL_W-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= SEL_W'(N_CH - 1);
        end else if (accept) begin
            ptr_reg <= grant_idx;
        end
    end

    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_sel;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            idx_sel = SEL_W'(idx);
            if (!grant_any && req[idx_sel]) begin
                grant_any = 1'b1;
                grant_idx = idx_sel;
            end
        end
    end

endmodule

// File: rtl/mux_demux_n.sv
// N-channel mux/demux through a single-beat slot register (EMPTY/FULL).
// Define MUX_DEMUX_ROUND_ROBIN_EN to pick the source by round-robin instead of src_sel.
module mux_demux_n
    import mux_demux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 2,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0][WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]            in_valid,
    output logic [N_CH-1:0]            in_ready,
    input  logic [SEL_W-1:0]           src_sel,
    input  logic [SEL_W-1:0]           dst_sel,
    output logic [N_CH-1:0][WIDTH-1:0] out_data,
    output logic [N_CH-1:0]            out_valid,
    input  logic [N_CH-1:0]            out_ready
);

    localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

    slot_state_t      state_reg, state_next;
    logic [WIDTH-1:0] data_reg;
    logic [SEL_W-1:0] dst_q_reg;

    logic [SEL_W-1:0] src_idx;
    logic             src_ok;
    logic             slot_free;
    logic             accept;

    logic dst_ok;
    assign dst_ok = ({1'b0, dst_sel} < N_CH_W);

`ifdef MUX_DEMUX_ROUND_ROBIN_EN
    logic grant_any;

    rr_arbiter_n #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .accept    (accept),
        .grant_idx (src_idx),
        .grant_any (grant_any)
    );

    assign src_ok = grant_any && dst_ok;
`else
    assign src_idx = src_sel;
    assign src_ok  = ({1'b0, src_sel} < N_CH_W) && dst_ok;
`endif

    // A new beat fits when the slot is empty or is draining this cycle.
    assign slot_free = (state_reg == EMPTY) || out_ready[dst_q_reg];
    assign accept    = src_ok && slot_free && in_valid[src_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            dst_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                data_reg  <= in_data[src_idx];
                dst_q_reg <= dst_sel;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (out_ready[dst_q_reg]) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign in_ready[gi]  = src_ok && slot_free && (src_idx == SEL_W'(gi));
            assign out_valid[gi] = (state_reg == FULL) && (dst_q_reg == SEL_W'(gi));
            assign out_data[gi]  = out_valid[gi] ? data_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mux_demux_n.sv
// Directed bench for mux_demux_n: a 4-channel and a 3-channel instance, 8-bit data.
// Round-robin grant order is exercised when MUX_DEMUX_ROUND_ROBIN_EN is defined.
module tb_mux_demux_n;

    logic clk;
    logic rst;

    logic [3:0][7:0] d4_in_data;
    logic [3:0]      d4_in_valid;
    logic [3:0]      d4_in_ready;
    logic [1:0]      d4_src_sel;
    logic [1:0]      d4_dst_sel;
    logic [3:0][7:0] d4_out_data;
    logic [3:0]      d4_out_valid;
    logic [3:0]      d4_out_ready;

    logic [2:0][7:0] d3_in_data;
    logic [2:0]      d3_in_valid;
    logic [2:0]      d3_in_ready;
    logic [1:0]      d3_src_sel;
    logic [1:0]      d3_dst_sel;
    logic [2:0][7:0] d3_out_data;
    logic [2:0]      d3_out_valid;
    logic [2:0]      d3_out_ready;

    int n_checks;
    int n_errors;

    mux_demux_n #(.N_CH(4), .WIDTH(8)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d4_in_data),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .src_sel   (d4_src_sel),
        .dst_sel   (d4_dst_sel),
        .out_data  (d4_out_data),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready)
    );

    mux_demux_n #(.N_CH(3), .WIDTH(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .src_sel   (d3_src_sel),
        .dst_sel   (d3_dst_sel),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        d4_in_data   = '0;
        d4_in_valid  = '0;
        d4_src_sel   = '0;
        d4_dst_sel   = '0;
        d4_out_ready = 4'hF;
        d3_in_data   = '0;
        d3_in_valid  = '0;
        d3_src_sel   = '0;
        d3_dst_sel   = '0;
        d3_out_ready = 3'h7;

        // Reset state
        step();
        check("rst_out_valid4", 32'(d4_out_valid), 32'h0);
        check("rst_out_data4", d4_out_data, 32'h0);
        check("rst_out_valid3", 32'(d3_out_valid), 32'h0);
`ifndef MUX_DEMUX_ROUND_ROBIN_EN
        check("rst_in_ready4", 32'(d4_in_ready), 32'h1);
`endif
        rst = 1'b0;
        step();

        // Single beat src 2 -> dst 1
        d4_src_sel    = 2'd2;
        d4_dst_sel    = 2'd1;
        d4_in_data[2] = 8'hA5;
        d4_in_valid   = 4'b0100;
        #1;
        check("t1_in_ready", 32'(d4_in_ready), 32'h4);
        step();
        d4_in_valid = 4'b0000;
        #1;
        check("t1_out_valid", 32'(d4_out_valid), 32'h2);
        check("t1_out_data", d4_out_data, 32'h0000_A500);
        step();
        check("t1_drained", 32'(d4_out_valid), 32'h0);

        // Backpressure on dst 1 for three cycles
        d4_out_ready = 4'b1101;
        d4_in_valid  = 4'b0100;
        #1;
        check("t2_in_ready_empty", 32'(d4_in_ready), 32'h4);
        step();
        d4_in_data[2] = 8'hFF;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_hold_valid_%0d", i), 32'(d4_out_valid), 32'h2);
            check($sformatf("t2_hold_data_%0d", i), d4_out_data, 32'h0000_A500);
            check($sformatf("t2_hold_ready_%0d", i), 32'(d4_in_ready), 32'h0);
            step();
        end
        d4_in_valid  = 4'b0000;
        d4_out_ready = 4'hF;
        #1;
        check("t2_ready_on_drain", 32'(d4_in_ready), 32'h4);
        step();
        check("t2_empty", 32'(d4_out_valid), 32'h0);

        // Eight back-to-back beats src 0 -> dst 3
        d4_src_sel    = 2'd0;
        d4_dst_sel    = 2'd3;
        d4_in_data[0] = 8'h10;
        d4_in_valid   = 4'b0001;
        #1;
        check("t3_in_ready_0", 32'(d4_in_ready), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t3_valid_%0d", k - 1), 32'(d4_out_valid), 32'h8);
            check($sformatf("t3_data_%0d", k - 1), d4_out_data, {8'(8'h10 + k - 1), 24'h0});
            if (k < 8) begin
                d4_in_data[0] = 8'(8'h10 + k);
                #1;
                check($sformatf("t3_in_ready_%0d", k), 32'(d4_in_ready), 32'h1);
            end else begin
                d4_in_valid = 4'b0000;
            end
        end
        step();
        check("t3_empty", 32'(d4_out_valid), 32'h0);

        // N_CH=3: out-of-range destination never accepted
        d3_src_sel    = 2'd0;
        d3_dst_sel    = 2'd3;
        d3_in_data[0] = 8'h77;
        d3_in_valid   = 3'b001;
        #1;
        check("t4_in_ready", 32'(d3_in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_no_out_%0d", i), 32'(d3_out_valid), 32'h0);
        end
`ifndef MUX_DEMUX_ROUND_ROBIN_EN
        d3_src_sel  = 2'd3;
        d3_dst_sel  = 2'd0;
        d3_in_valid = 3'b111;
        #1;
        check("t4_bad_src_ready", 32'(d3_in_ready), 32'h0);
        step();
        check("t4_bad_src_no_out", 32'(d3_out_valid), 32'h0);
`endif
        d3_in_valid = 3'b000;

        // Reset while FULL discards the beat
        d4_src_sel    = 2'd2;
        d4_dst_sel    = 2'd1;
        d4_in_data[2] = 8'h5A;
        d4_out_ready  = 4'b1101;
        d4_in_valid   = 4'b0100;
        step();
        d4_in_valid = 4'b0000;
        #1;
        check("t5_full", 32'(d4_out_valid), 32'h2);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(d4_out_valid), 32'h0);
        check("t5_rst_data", d4_out_data, 32'h0);
        step();
        rst          = 1'b0;
        d4_out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_after_rst_%0d", i), 32'(d4_out_valid), 32'h0);
        end

`ifdef MUX_DEMUX_ROUND_ROBIN_EN
        // Round-robin order from reset pointer: 0,1,2,3,0
        d4_in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        d4_dst_sel   = 2'd0;
        d4_out_ready = 4'hF;
        d4_in_valid  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % 4;
            #1;
            check($sformatf("rr_grant_%0d", i), 32'(d4_in_ready), 32'(1 << g));
            step();
            check($sformatf("rr_data_%0d", i), d4_out_data, 32'(g * 8'h11));
        end
        d4_in_valid = 4'h0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_demux_n.md
MUX_DEMUX_N -- requirements
Module: mux_demux_n

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input and output channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 2, data bits per channel.
REQ-003 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  [N_CH][WIDTH]  per-channel input data.
REQ-006 SHALL have port in_valid  input  N_CH  per-channel input valid.
REQ-007 SHALL have port in_ready  output  N_CH  per-channel input ready.
REQ-008 SHALL have port src_sel  input  SEL_W=$clog2(N_CH)  source channel select.
REQ-009 SHALL have port dst_sel  input  SEL_W  destination channel select, sampled with the accepted beat.
REQ-010 SHALL have port out_data  output  [N_CH][WIDTH]  per-channel output data.
REQ-011 SHALL have port out_valid  output  N_CH  per-channel output valid.
REQ-012 SHALL have port out_ready  input  N_CH  per-channel output ready.

Function
REQ-013 SHALL hold one beat in a slot register with stored destination dst_q; states EMPTY and FULL.
REQ-014 SHALL assert in_ready[src_sel] only, when slot EMPTY or (FULL and out_ready[dst_q]); all other in_ready bits 0.
REQ-015 SHALL accept a beat when in_valid[src_sel] and in_ready[src_sel]; data and dst_sel captured; latency 1 cycle to out_valid.
REQ-016 SHALL in FULL drive out_valid[dst_q]=1, out_data[dst_q]=slot data; all other out_valid 0 and out_data 0.
REQ-017 SHALL in EMPTY drive all out_valid 0 and all out_data 0.
REQ-018 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on drain (out_ready[dst_q]) without accept; FULL->FULL with new data/dst on simultaneous drain and accept (full throughput, 1 beat/cycle).
REQ-019 SHALL hold slot data and dst_q stable while FULL and out_ready[dst_q]=0.
REQ-020 SHALL treat src_sel>=N_CH or dst_sel>=N_CH (non-power-of-two N_CH) as no accept: all in_ready 0.
REQ-021 SHALL keep in_ready combinationally independent of in_valid.

Reset
REQ-022 SHALL on rst clear state to EMPTY, dst_q=0, slot data=0, all out_valid 0, all out_data 0, RR pointer to N_CH-1, immediately and asynchronously.
REQ-023 SHALL discard a held beat when rst asserts mid-operation; no output beat after release until a new accept.

Configuration
REQ-024 SHALL support macro MUX_DEMUX_ROUND_ROBIN_EN.
REQ-025 SHALL without the macro select the source by src_sel as above.
REQ-026 SHALL with the macro ignore src_sel; source = first channel with in_valid set searching upward from (pointer+1) modulo N_CH; pointer updated to granted channel on accept only; in_ready asserted only on the granted channel.

Structure
REQ-027 SHALL place the state enum (EMPTY, FULL) and SEL_W helper function in package mux_demux_pkg.
REQ-028 SHALL implement round-robin grant as sub-module rr_arbiter_n (parameter N_CH), instantiated only under MUX_DEMUX_ROUND_ROBIN_EN.

Verification
REQ-029 SHALL test: N_CH=4, WIDTH=8, src_sel=2, dst_sel=1, in_data[2]=0xA5, out_ready all 1 -> next cycle out_valid=0010, out_data[1]=0xA5, others 0.
REQ-030 SHALL test: out_ready[1]=0 for 3 cycles while FULL -> out_data[1] stable 0xA5, in_ready all 0; out_ready[1]=1 -> drain, EMPTY next cycle.
REQ-031 SHALL test: back-to-back 8 beats src 0->dst 3, out_ready=1111 -> 8 outputs on consecutive cycles, in order, no bubbles.
REQ-032 SHALL test: N_CH=3, dst_sel=3 with in_valid -> in_ready all 0, no output ever.
REQ-033 SHALL test: rst asserted while FULL -> out_valid 0 in same cycle, remains 0 after release.
REQ-034 SHALL test with MUX_DEMUX_ROUND_ROBIN_EN: in_valid=1111 constant, out_ready=1111 -> grants 0,1,2,3,0 on successive accepts.
